// File: rtl/matrix_input_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_input_parser
// Purpose  : Parses ASCII decimal tokens from the UART byte stream and serves
//            matrix store, dimension query and ID query tasks.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_input_parser #(
    parameter int MAX_DIM = 5,
    parameter int MAX_VAL = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        en_input,
    input  logic        is_gen_mode,
    input  logic [1:0]  task_mode,
    input  logic        addr_ready,
    input  logic [7:0]  base_addr,
    output logic        dims_valid,
    output logic [31:0] dim_m,
    output logic [31:0] dim_n,
    output logic        id_valid,
    output logic [31:0] id_val,
    output logic        rx_done,
    output logic        error_flag,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GET_M     = 4'd1;
    localparam logic [3:0] S_GET_N     = 4'd2;
    localparam logic [3:0] S_WAIT_ADDR = 4'd3;
    localparam logic [3:0] S_FILL_MAN  = 4'd4;
    localparam logic [3:0] S_FILL_GEN  = 4'd5;
    localparam logic [3:0] S_GET_ID    = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    localparam logic [7:0] C_MAX_DIM   = 8'(MAX_DIM);
    localparam logic [7:0] C_MAX_VAL   = 8'(MAX_VAL);
    localparam logic [7:0] C_VAL_MOD   = 8'(MAX_VAL + 1);
    localparam logic [7:0] C_LFSR_SEED = 8'hA5;

    logic [3:0]  r_state;
    logic        r_dims_only;
    logic        r_gen;
    logic [7:0]  r_acc;
    logic        r_have_digit;
    logic        r_tok_valid;
    logic        r_tok_err;
    logic [7:0]  r_tok_val;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_base;
    logic [15:0] r_idx;
    logic [7:0]  r_dim_m;
    logic [7:0]  r_dim_n;
    logic [7:0]  r_id;
    logic        r_dims_valid;
    logic        r_id_valid;
    logic        r_rx_done;
    logic        r_error;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [7:0]  r_mem_wdata;

    logic        w_parsing;
    logic        w_is_digit;
    logic        w_is_sep;
    logic [11:0] w_acc_mul;
    logic [7:0]  w_acc_next;
    logic [15:0] w_total;
    logic [15:0] w_idx_next;
    logic        w_last;
    logic        w_dim_ok;
    logic [7:0]  w_gen_data;
    logic        w_lfsr_fb;

    assign w_parsing  = en_input && ((r_state == S_GET_M) || (r_state == S_GET_N) ||
                                     (r_state == S_FILL_MAN) || (r_state == S_GET_ID));
    assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    // Low nibble of an ASCII digit is its value
    assign w_acc_mul  = ({4'b0, r_acc} * 12'd10) + {8'b0, rx_data[3:0]};
    assign w_acc_next = (w_acc_mul > 12'd255) ? 8'hFF : w_acc_mul[7:0];
    assign w_total    = {8'b0, r_dim_m} * {8'b0, r_dim_n};
    assign w_idx_next = r_idx + 16'd1;
    assign w_last     = (w_idx_next == w_total);
    assign w_dim_ok   = (r_tok_val >= 8'd1) && (r_tok_val <= C_MAX_DIM);
    assign w_gen_data = r_lfsr % C_VAL_MOD;
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= C_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Tokenizer: a completed token is presented to the FSM one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= 8'd0;
            r_have_digit <= 1'b0;
            r_tok_valid  <= 1'b0;
            r_tok_err    <= 1'b0;
            r_tok_val    <= 8'd0;
        end else begin
            r_tok_valid <= 1'b0;
            r_tok_err   <= 1'b0;
            if (!w_parsing) begin
                r_acc        <= 8'd0;
                r_have_digit <= 1'b0;
            end else if (rx_valid) begin
                if (w_is_digit) begin
                    r_acc        <= w_acc_next;
                    r_have_digit <= 1'b1;
                end else if (w_is_sep) begin
                    if (r_have_digit) begin
                        r_tok_valid  <= 1'b1;
                        r_tok_val    <= r_acc;
                        r_acc        <= 8'd0;
                        r_have_digit <= 1'b0;
                    end
                end else begin
                    r_tok_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_dims_only  <= 1'b0;
            r_gen        <= 1'b0;
            r_base       <= 8'd0;
            r_idx        <= 16'd0;
            r_dim_m      <= 8'd0;
            r_dim_n      <= 8'd0;
            r_id         <= 8'd0;
            r_dims_valid <= 1'b0;
            r_id_valid   <= 1'b0;
            r_rx_done    <= 1'b0;
            r_error      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 8'd0;
            r_mem_wdata  <= 8'd0;
        end else begin
            r_mem_we   <= 1'b0;
            r_id_valid <= 1'b0;
            r_rx_done  <= 1'b0;
            if (!en_input) begin
                r_state      <= S_IDLE;
                r_dims_valid <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dims_only <= (task_mode == 2'd1) || (task_mode == 2'd3);
                        r_gen       <= is_gen_mode;
                        r_state     <= (task_mode == 2'd2) ? S_GET_ID : S_GET_M;
                    end
                    S_GET_M: begin
                        if (r_tok_err || (r_tok_valid && !w_dim_ok)) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (r_tok_valid) begin
                            r_dim_m <= r_tok_val;
                            r_state <= S_GET_N;
                        end
                    end
                    S_GET_N: begin
                        if (r_tok_err || (r_tok_valid && !w_dim_ok)) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (r_tok_valid) begin
                            r_dim_n      <= r_tok_val;
                            r_dims_valid <= 1'b1;
                            r_state      <= r_dims_only ? S_DONE : S_WAIT_ADDR;
                        end
                    end
                    S_WAIT_ADDR: begin
                        if (addr_ready) begin
                            r_base       <= base_addr;
                            r_dims_valid <= 1'b0;
                            if (r_gen) begin
                                // First generated element goes out on the sampling edge
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= base_addr;
                                r_mem_wdata <= w_gen_data;
                                r_idx       <= 16'd1;
                                r_state     <= (w_total == 16'd1) ? S_DONE : S_FILL_GEN;
                            end else begin
                                r_idx   <= 16'd0;
                                r_state <= S_FILL_MAN;
                            end
                        end
                    end
                    S_FILL_MAN: begin
                        if (r_tok_err || (r_tok_valid && (r_tok_val > C_MAX_VAL))) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (r_tok_valid) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_base + r_idx[7:0];
                            r_mem_wdata <= r_tok_val;
                            r_idx       <= w_idx_next;
                            if (w_last) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_FILL_GEN: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_base + r_idx[7:0];
                        r_mem_wdata <= w_gen_data;
                        r_idx       <= w_idx_next;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_GET_ID: begin
                        if (r_tok_err) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (r_tok_valid) begin
                            r_id       <= r_tok_val;
                            r_id_valid <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_rx_done    <= 1'b1;
                        r_dims_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                    S_ERR: begin
                        r_error <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dims_valid = r_dims_valid;
    assign dim_m      = {24'd0, r_dim_m};
    assign dim_n      = {24'd0, r_dim_n};
    assign id_valid   = r_id_valid;
    assign id_val     = {24'd0, r_id};
    assign rx_done    = r_rx_done;
    assign error_flag = r_error;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_matrix_input_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_input_parser
// Purpose  : Directed self-checking bench for matrix_input_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_input_parser;

    localparam int MAX_VAL = 9;
    localparam int W_DIMS = 0, W_DONE = 1, W_ID = 2, W_ERR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        en_input;
    logic        is_gen_mode;
    logic [1:0]  task_mode;
    logic        addr_ready;
    logic [7:0]  base_addr;
    logic        dims_valid;
    logic [31:0] dim_m;
    logic [31:0] dim_n;
    logic        id_valid;
    logic [31:0] id_val;
    logic        rx_done;
    logic        error_flag;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    matrix_input_parser #(.MAX_DIM(5), .MAX_VAL(MAX_VAL)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .en_input(en_input), .is_gen_mode(is_gen_mode), .task_mode(task_mode),
        .addr_ready(addr_ready), .base_addr(base_addr), .dims_valid(dims_valid),
        .dim_m(dim_m), .dim_n(dim_n), .id_valid(id_valid), .id_val(id_val),
        .rx_done(rx_done), .error_flag(error_flag), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    int          total = 0;
    int          bad = 0;
    int          model_tok[$];
    logic [15:0] exp_wr[$];
    logic [15:0] wr_item;
    int          exp_m = 0, exp_n = 0, exp_id = 0;
    int          gen_left = 0;
    logic [7:0]  gen_addr = 8'd0;
    bit          gen_active = 0;
    bit          done_after_we = 0;
    bit          prev_we = 0, prev_done = 0;
    int          wr_cnt = 0, done_cnt = 0, id_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Token values the byte stream must yield: digits accumulate with
    // saturation at 255, separators close non-empty tokens only.
    function automatic void tokenize(input string s);
        int  acc;
        bit  seen;
        byte c;
        model_tok.delete();
        acc  = 0;
        seen = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c >= 8'h30 && c <= 8'h39) begin
                acc = acc * 10 + int'(c - 8'h30);
                if (acc > 255) acc = 255;
                seen = 1;
            end else if ((c == 8'h20 || c == 8'h0A || c == 8'h0D) && seen) begin
                model_tok.push_back(acc);
                acc  = 0;
                seen = 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_cnt++;
                if (gen_left > 0) begin
                    check("gen_addr", {24'd0, mem_addr}, {24'd0, gen_addr});
                    check("gen_data_range", {31'd0, (int'(mem_wdata) <= MAX_VAL)}, 32'd1);
                    gen_addr   = gen_addr + 8'd1;
                    gen_left   = gen_left - 1;
                    gen_active = 1;
                end else if (exp_wr.size() > 0) begin
                    wr_item = exp_wr.pop_front();
                    check("write_addr", {24'd0, mem_addr}, {24'd0, wr_item[15:8]});
                    check("write_data", {24'd0, mem_wdata}, {24'd0, wr_item[7:0]});
                end else begin
                    check("unexpected_write", {31'd0, mem_we}, 32'd0);
                end
            end else if (gen_active && gen_left > 0) begin
                check("gen_back_to_back", {31'd0, mem_we}, 32'd1);
            end
            if (gen_left == 0) gen_active = 0;
            if (dims_valid) begin
                check("dims_m_while_valid", dim_m, exp_m);
                check("dims_n_while_valid", dim_n, exp_n);
            end
            if (id_valid) begin
                id_cnt++;
                check("id_val_on_pulse", id_val, exp_id);
            end
            if (rx_done) begin
                done_cnt++;
                check("rx_done_one_cycle", {31'd0, prev_done}, 32'd0);
                if (done_after_we) check("rx_done_after_last_write", {31'd0, prev_we}, 32'd1);
            end
            prev_we   = mem_we;
            prev_done = rx_done;
        end else begin
            prev_we   = 0;
            prev_done = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic start_task(input logic [1:0] mode, input logic gen);
        task_mode   = mode;
        is_gen_mode = gen;
        en_input    = 1'b1;
        tick();
    endtask

    task automatic stop_task();
        en_input = 1'b0;
        tick();
        tick();
    endtask

    task automatic give_addr(input logic [7:0] b);
        base_addr  = b;
        addr_ready = 1'b1;
        tick();
        addr_ready = 1'b0;
    endtask

    function automatic bit sig_of(input int sel);
        case (sel)
            W_DIMS:  return dims_valid;
            W_DONE:  return rx_done;
            W_ID:    return id_valid;
            default: return error_flag;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (sig_of(sel)) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s: got timeout after %0d cycles want signal high", name, budget);
        end
    endtask

    task automatic error_case(input logic [1:0] mode, input string s, input string name);
        start_task(mode, 1'b0);
        send_str(s);
        wait_for(W_ERR, 20, name);
        check({name, "_flag"}, {31'd0, error_flag}, 32'd1);
        stop_task();
        check({name, "_clear"}, {31'd0, error_flag}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_data = 8'd0; rx_valid = 1'b0; en_input = 1'b0; is_gen_mode = 1'b0;
        task_mode = 2'd0; addr_ready = 1'b0; base_addr = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dims_valid", {31'd0, dims_valid}, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("rst_error_flag", {31'd0, error_flag}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_dim_m", dim_m, 32'd0);
        check("rst_id_val", id_val, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Manual store 2x3 at 0x10
        tokenize("2 3 ");
        check("model_dims", model_tok[0] * 10 + model_tok[1], 32'd23);
        exp_m = model_tok[0]; exp_n = model_tok[1];
        wr_cnt = 0; done_cnt = 0;
        start_task(2'd0, 1'b0);
        send_str("2 3 ");
        wait_for(W_DIMS, 20, "manual_dims_valid");
        check("manual_dim_m", dim_m, 32'd2);
        check("manual_dim_n", dim_n, 32'd3);
        tick();
        check("manual_dims_held", {31'd0, dims_valid}, 32'd1);
        tokenize("1 2 3 4 5 6 ");
        for (int i = 0; i < model_tok.size(); i++)
            exp_wr.push_back({8'h10 + 8'(i), 8'(model_tok[i])});
        done_after_we = 1;
        give_addr(8'h10);
        check("manual_dims_drop", {31'd0, dims_valid}, 32'd0);
        send_str("1 2 3 4 5 6 ");
        wait_for(W_DONE, 20, "manual_rx_done");
        check("manual_writes_left", exp_wr.size(), 32'd0);
        check("manual_write_count", wr_cnt, 32'd6);
        stop_task();
        check("manual_done_count", done_cnt, 32'd1);

        // Generated store 5x5 wrapping from 0xF0
        exp_m = 5; exp_n = 5; wr_cnt = 0;
        start_task(2'd0, 1'b1);
        send_str("5 5 ");
        wait_for(W_DIMS, 20, "gen_dims_valid");
        check("gen_dim_m", dim_m, 32'd5);
        gen_left = 25; gen_addr = 8'hF0;
        give_addr(8'hF0);
        check("gen_first_write", {31'd0, mem_we}, 32'd1);
        wait_for(W_DONE, 40, "gen_rx_done");
        check("gen_left", gen_left, 32'd0);
        check("gen_write_count", wr_cnt, 32'd25);
        check("gen_wrap_end", {24'd0, gen_addr}, 32'h09);
        stop_task();
        done_after_we = 0;

        // Dimension query with CR LF separator
        exp_m = 3; exp_n = 4; wr_cnt = 0; done_cnt = 0;
        start_task(2'd1, 1'b0);
        send_str("3");
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_str("4 ");
        wait_for(W_DIMS, 20, "query_dims_valid");
        check("query_dim_m", dim_m, 32'd3);
        check("query_dim_n", dim_n, 32'd4);
        @(negedge clk);
        check("query_dims_pulse", {31'd0, dims_valid}, 32'd0);
        check("query_rx_done", {31'd0, rx_done}, 32'd1);
        stop_task();
        check("query_no_writes", wr_cnt, 32'd0);

        // ID query; byte arriving with the enable edge is dropped
        tokenize("  2\n");
        check("model_id", model_tok[0], 32'd2);
        exp_id = model_tok[0]; id_cnt = 0;
        task_mode = 2'd2; en_input = 1'b1;
        send_byte(8'h37);
        send_str("  2\n");
        wait_for(W_ID, 20, "id_valid");
        check("id_val", id_val, 32'd2);
        @(negedge clk);
        check("id_pulse_width", {31'd0, id_valid}, 32'd0);
        check("id_rx_done", {31'd0, rx_done}, 32'd1);
        stop_task();

        tokenize("300 ");
        check("model_saturate", model_tok[0], 32'd255);
        exp_id = model_tok[0];
        start_task(2'd2, 1'b0);
        send_str("300 ");
        wait_for(W_ID, 20, "id_sat_valid");
        check("id_sat_val", id_val, 32'd255);
        stop_task();
        check("id_pulse_count", id_cnt, 32'd2);

        // Error cases
        error_case(2'd0, "6 ", "err_m_too_big");
        error_case(2'd0, "0 ", "err_m_zero");
        error_case(2'd0, "2a", "err_bad_char");
        exp_m = 1; exp_n = 1; wr_cnt = 0;
        start_task(2'd0, 1'b0);
        send_str("1 1 ");
        wait_for(W_DIMS, 20, "err_elem_dims");
        give_addr(8'h40);
        send_str("12 ");
        wait_for(W_ERR, 20, "err_elem_big");
        stop_task();
        check("err_elem_clear", {31'd0, error_flag}, 32'd0);
        check("err_elem_no_write", wr_cnt, 32'd0);

        // Abort mid manual fill after two of four elements
        exp_m = 2; exp_n = 2; wr_cnt = 0;
        start_task(2'd0, 1'b0);
        send_str("2 2 ");
        wait_for(W_DIMS, 20, "abort_dims");
        exp_wr.push_back({8'h80, 8'd9});
        exp_wr.push_back({8'h81, 8'd0});
        give_addr(8'h80);
        send_str("9 0 ");
        repeat (3) tick();
        check("abort_partial_writes", exp_wr.size(), 32'd0);
        en_input = 1'b0;
        send_str("5 5 ");
        tick();
        check("abort_dims_valid", {31'd0, dims_valid}, 32'd0);
        check("abort_write_count", wr_cnt, 32'd2);
        exp_m = 1; exp_n = 5; done_cnt = 0;
        start_task(2'd3, 1'b0);
        send_str("1 5 ");
        wait_for(W_DIMS, 20, "restart_dims");
        check("restart_dim_n", dim_n, 32'd5);
        wait_for(W_DONE, 10, "restart_done");
        stop_task();

        // Asynchronous reset in the middle of a generated fill
        exp_m = 4; exp_n = 4;
        start_task(2'd0, 1'b1);
        send_str("4 4 ");
        wait_for(W_DIMS, 20, "rstgen_dims");
        gen_left = 16; gen_addr = 8'h00;
        give_addr(8'h00);
        repeat (3) tick();
        #2;
        gen_left = 0; gen_active = 0;
        rst_n = 1'b0;
        #1;
        check("rstgen_mem_we", {31'd0, mem_we}, 32'd0);
        check("rstgen_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rstgen_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rstgen_dims_valid", {31'd0, dims_valid}, 32'd0);
        check("rstgen_dim_m", dim_m, 32'd0);
        en_input = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
